// File: rtl/cpu_io_pkg.sv
// -----------------------------------------------------------------------------
// cpu_io_pkg
// Shared definitions for the CPU memory-mapped I/O responder.
//   - OP_CODE_* : raw 2-bit op encodings, shared with the CPU memory stage
//   - op_t      : typed view of the CPU op bus
//   - state_t   : responder FSM states
// -----------------------------------------------------------------------------
package cpu_io_pkg;

    localparam logic [1:0] OP_CODE_NOP   = 2'b00;
    localparam logic [1:0] OP_CODE_READ  = 2'b01;
    localparam logic [1:0] OP_CODE_WRITE = 2'b10;
    localparam logic [1:0] OP_CODE_DMA   = 2'b11;

    typedef enum logic [1:0] {
        OP_NOP   = OP_CODE_NOP,
        OP_READ  = OP_CODE_READ,
        OP_WRITE = OP_CODE_WRITE,
        OP_DMA   = OP_CODE_DMA
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_RESP,
        ST_WR_DONE,
        ST_DMA_REQ,
        ST_DMA_FILL,
        ST_DMA_DONE
    } state_t;

endpackage : cpu_io_pkg

// File: rtl/io_scratch_ram.sv
// -----------------------------------------------------------------------------
// io_scratch_ram
// Single-port synchronous scratchpad, DEPTH x DATAW, one-cycle read latency.
// A write and a read of the same address in one cycle returns the old word.
//   clk      in   clock
//   we_i     in   write enable
//   addr_i   in   word index
//   wdata_i  in   write data
//   rdata_o  out  registered read data of the word addressed last cycle
// -----------------------------------------------------------------------------
module io_scratch_ram #(
    parameter int DATAW = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [DATAW-1:0] wdata_i,
    output logic [DATAW-1:0] rdata_o
);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [DATAW-1:0] rdata_q;

    // NOTE: the storage array has no reset; contents survive a responder reset
    // and the array maps cleanly onto a RAM macro.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule : io_scratch_ram

// File: rtl/cpu_io_responder.sv
// -----------------------------------------------------------------------------
// cpu_io_responder
// Target-side responder for the CPU memory-mapped I/O port. Serves READ and
// WRITE from a local scratchpad and performs line fills (DMA) from the host.
//   clk         in   clock (rising edge)
//   rst         in   asynchronous active-high reset
//   op          in   CPU request: NOP / READ / WRITE / DMA
//   cpu_addr    in   request word address
//   cpu_out     in   CPU write data
//   cpu_in      out  read data, held until the next read response
//   rd_valid    out  one-cycle pulse, cpu_in valid
//   tx_done     out  one-cycle pulse, WRITE committed or DMA line complete
//   dma_ready   out  responder idle, an op is accepted this cycle
//   dma_req     out  line-fill request, held until granted
//   dma_addr    out  line-aligned base address of the fill
//   dma_gnt     in   host accepts the request
//   dma_wvalid  in   host fill word valid
//   dma_wdata   in   host fill word
// -----------------------------------------------------------------------------
module cpu_io_responder
    import cpu_io_pkg::*;
#(
    parameter int DATAW      = 32,
    parameter int ADDRW      = 32,
    parameter int DEPTH      = 1024,
    parameter int LINE_WORDS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic [ADDRW-1:0] cpu_addr,
    input  logic [DATAW-1:0] cpu_out,
    output logic [DATAW-1:0] cpu_in,
    output logic             rd_valid,
    output logic             tx_done,
    output logic             dma_ready,
    output logic             dma_req,
    output logic [ADDRW-1:0] dma_addr,
    input  logic             dma_gnt,
    input  logic             dma_wvalid,
    input  logic [DATAW-1:0] dma_wdata
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int CNTW = $clog2(LINE_WORDS) + 1;

    localparam logic [ADDRW-1:0] DEPTH_A   = ADDRW'(DEPTH);
    localparam logic [ADDRW-1:0] LINE_MASK = ~ADDRW'(LINE_WORDS - 1);
    localparam logic [CNTW-1:0]  LAST_CNT  = CNTW'(LINE_WORDS - 1);

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [ADDRW-1:0] dma_addr_q, dma_addr_d;
    logic [DATAW-1:0] cpu_in_q, cpu_in_d;
    logic             rd_in_range_q, rd_in_range_d;

    op_t              op_req;
    logic             cpu_in_range;
    logic             line_in_range;
    logic [IDXW-1:0]  cpu_idx;
    logic [IDXW-1:0]  fill_idx;

    logic             ram_we;
    logic [IDXW-1:0]  ram_addr;
    logic [DATAW-1:0] ram_wdata;
    logic [DATAW-1:0] ram_rdata;

    assign op_req        = op_t'(op);
    assign cpu_in_range  = (cpu_addr < DEPTH_A);
    // DEPTH is a multiple of LINE_WORDS, so a line is entirely in or out.
    assign line_in_range = (dma_addr_q < DEPTH_A);
    assign cpu_idx       = cpu_addr[IDXW-1:0];
    // The base is line-aligned and cnt_q < LINE_WORDS, so the sum never carries
    // into the base bits.
    assign fill_idx      = dma_addr_q[IDXW-1:0] + IDXW'(cnt_q);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its _d value from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dma_addr_q    <= '0;
            cpu_in_q      <= '0;
            rd_in_range_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dma_addr_q    <= dma_addr_d;
            cpu_in_q      <= cpu_in_d;
            rd_in_range_q <= rd_in_range_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a hold default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dma_addr_d    = dma_addr_q;
        cpu_in_d      = cpu_in_q;
        rd_in_range_d = rd_in_range_q;

        unique case (state_q)
            ST_IDLE: begin
                unique case (op_req)
                    OP_READ: begin
                        state_d       = ST_RD;
                        rd_in_range_d = cpu_in_range;
                    end
                    OP_WRITE: begin
                        state_d = ST_WR_DONE;
                    end
                    OP_DMA: begin
                        state_d    = ST_DMA_REQ;
                        dma_addr_d = cpu_addr & LINE_MASK;
                    end
                    default: begin
                    end
                endcase
            end

            // The RAM word addressed in IDLE is on ram_rdata during RD.
            ST_RD: begin
                state_d  = ST_RD_RESP;
                cpu_in_d = rd_in_range_q ? ram_rdata : '0;
            end

            ST_RD_RESP,
            ST_WR_DONE,
            ST_DMA_DONE: begin
                state_d = ST_IDLE;
            end

            ST_DMA_REQ: begin
                if (dma_gnt) begin
                    state_d = ST_DMA_FILL;
                    cnt_d   = '0;
                end
            end

            ST_DMA_FILL: begin
                if (dma_wvalid) begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DMA_DONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: handshake flags decode the registered state; RAM control
    // is steered by whichever state owns the single port.
    // -------------------------------------------------------------------------
    always_comb begin
        dma_ready = (state_q == ST_IDLE);
        rd_valid  = (state_q == ST_RD_RESP);
        tx_done   = (state_q == ST_WR_DONE) || (state_q == ST_DMA_DONE);
        dma_req   = (state_q == ST_DMA_REQ);

        ram_we    = 1'b0;
        ram_addr  = cpu_idx;
        ram_wdata = cpu_out;

        if ((state_q == ST_IDLE) && (op_req == OP_WRITE) && cpu_in_range) begin
            ram_we = 1'b1;
        end

        if (state_q == ST_DMA_FILL) begin
            ram_addr  = fill_idx;
            ram_wdata = dma_wdata;
            ram_we    = dma_wvalid && line_in_range;
        end
    end

    assign cpu_in   = cpu_in_q;
    assign dma_addr = dma_addr_q;

    io_scratch_ram #(
        .DATAW (DATAW),
        .DEPTH (DEPTH),
        .AW    (IDXW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule : cpu_io_responder

// File: doc/cpu_io_responder.md
# cpu_io_responder

Target-side responder for the CPU's memory-mapped I/O port. It accepts the CPU's 2-bit `op` with `cpu_addr` and `cpu_out`, and services each request from a local word-addressed scratchpad. It answers with `cpu_in`/`rd_valid` for reads and `tx_done` for completed writes and line fills. Line fills (op DMA) are fetched from the host over a simple request/grant/stream interface, and `dma_ready` tells the CPU when a new op may be issued.

## Interface
- `DATAW`, 32: data word width.
- `ADDRW`, 32: CPU address width (word address).
- `DEPTH`, 1024: scratchpad words; power of two.
- `LINE_WORDS`, 8: words per DMA line fill; power of two, ≤ DEPTH.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  2  CPU request: 00 NOP, 01 READ, 10 WRITE, 11 DMA (line fill).
- `cpu_addr`  in  ADDRW  request word address.
- `cpu_out`  in  DATAW  CPU write data.
- `cpu_in`  out  DATAW  read data returned to the CPU.
- `rd_valid`  out  1  one-cycle pulse: `cpu_in` is valid.
- `tx_done`  out  1  one-cycle pulse: WRITE committed or DMA line complete.
- `dma_ready`  out  1  responder idle; an op is accepted this cycle.
- `dma_req`  out  1  line-fill request to the host; held until granted.
- `dma_addr`  out  ADDRW  line base address, `cpu_addr` with the low log2(LINE_WORDS) bits cleared.
- `dma_gnt`  in  1  host accepts the request.
- `dma_wvalid`  in  1  host fill word valid.
- `dma_wdata`  in  DATAW  host fill word.

## Operation
- FSM states:
  - IDLE
  - RD (RAM access)
  - RD_RESP
  - WR_DONE
  - DMA_REQ
  - DMA_FILL
  - DMA_DONE
- `dma_ready` = (state == IDLE).
- **Accepting ops:**
  - An op is sampled only when the FSM is in IDLE and `op != 00`.
  - `op` is ignored in every other state.
  - The CPU drives a non-NOP op for exactly one cycle.
- **Address map:**
  - In range: `cpu_addr < DEPTH`; the index is `cpu_addr[log2(DEPTH)-1:0]`.
  - Out-of-range READ returns 0.
  - Out-of-range WRITE is dropped, but `tx_done` still pulses.
  - Out-of-range DMA: the line is fetched and the words are discarded; `tx_done` still pulses.
- **READ:** IDLE→RD→RD_RESP→IDLE. In RD_RESP, `rd_valid`=1 and `cpu_in` is registered with the word. `cpu_in` holds its value until the next read response.
- **WRITE:** the RAM is written on the accepting edge. Then IDLE→WR_DONE (`tx_done`=1)→IDLE.
- **DMA:**
  - IDLE→DMA_REQ. In DMA_REQ, `dma_req`=1 and `dma_addr` is registered.
  - On `dma_gnt`=1 → DMA_FILL, with the word counter cleared.
  - Each `dma_wvalid` cycle writes `dma_wdata` to base+count and increments count (width log2(LINE_WORDS)+1).
  - After the LINE_WORDS-th word → DMA_DONE (`tx_done`=1) → IDLE.
  - `dma_wvalid` outside DMA_FILL is ignored.
  - Gaps in `dma_wvalid` stall the fill indefinitely; there is no timeout.
- **Reset** (asynchronous, any time, including mid-DMA):
  - State → IDLE; counter and `dma_addr` → 0.
  - Outputs: `cpu_in`=0, `rd_valid`=0, `tx_done`=0, `dma_req`=0, `dma_ready`=1 (immediately after reset asserts).
  - Scratchpad contents are not cleared; a partial line stays in place.
- `rd_valid` and `tx_done` are never high in the same cycle.

## Timing
- Cycle 0 is the accepting cycle.
- **READ:** `rd_valid` is high in cycle 2 (latency 2). `dma_ready` is low in cycles 1–2 and high in cycle 3.
- **WRITE:** `tx_done` is high in cycle 1. `dma_ready` is low in cycle 1 and high in cycle 2. A READ of the same address accepted in cycle 2 returns the new data.
- **DMA:**
  - `dma_req` rises in cycle 1.
  - `dma_gnt` in cycle g moves the FSM to DMA_FILL in cycle g+1. `dma_req` drops in cycle g+1.
  - With back-to-back `dma_wvalid` from g+1 to g+LINE_WORDS, `tx_done` is high in cycle g+LINE_WORDS+1.
  - Minimum busy time: LINE_WORDS+3 cycles.
- The scratchpad is synchronous single-port with 1-cycle read latency. The FSM serialises all access, so there are no port conflicts.

## Structure
- Package `cpu_io_pkg` holds:
  - the `op_t` enum (NOP/READ/WRITE/DMA);
  - the `state_t` enum;
  - op encoding constants shared with the CPU's memory stage.
- One sub-module, `io_scratch_ram`: single-port synchronous RAM, DEPTH×DATAW, with write enable. The top level contains the FSM, counter, address alignment and output registers.

## Test plan
- Reset values: assert `rst` mid-idle → `dma_ready`=1, `rd_valid`=`tx_done`=`dma_req`=0, `cpu_in`=0.
- Write then read:
  - WRITE addr 5, data 0xDEADBEEF → `tx_done` pulses in cycle 1.
  - READ addr 5 at the next `dma_ready` → `rd_valid` in cycle 2 with `cpu_in`=0xDEADBEEF.
- DMA fill:
  - DMA addr 0x13 → `dma_addr`=0x10.
  - Grant after 3 cycles, stream 0x100..0x107 with one idle gap → `tx_done` once after the 8th word.
  - READ 0x17 returns 0x107.
- Op ignored while busy: issue READ during DMA_FILL → no `rd_valid`, and fill data is unaffected.
- Out of range (DEPTH=1024):
  - WRITE addr 2048 → `tx_done` pulses and no RAM word changes.
  - READ addr 2048 → `cpu_in`=0.
- Reset mid-DMA after 4 of 8 words:
  - Response: FSM idle, `dma_req`=0, no `tx_done`.
  - Words 0–3 are retained.
  - A new DMA completes normally.
